// File: rtl/clint_responder_pkg.sv
// Shared constants for the CLINT responder: register offsets and bus FSM state encoding.
package clint_responder_pkg;

  // Register offsets within the 64 KiB window (bits [2:0] are don't-care).
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  // Bus responder FSM states.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  // Doubleword-granular offset compare.
  function automatic logic off_match(input logic [15:0] a, input logic [15:0] b);
    return a[15:3] == b[15:3];
  endfunction

endpackage

// File: rtl/clint_responder_bus_resp_fsm.sv
// Generic bus responder handshake: address-phase latch, wait-state counter, HREADY.
module clint_responder_bus_resp_fsm
  import clint_responder_pkg::*;
#(
  parameter logic [63:0] BASE        = 64'h0200_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hsel,
  input  logic        i_htrans,
  input  logic [15:0] i_haddr,
  input  logic        i_hwrite,
  output logic        o_hready,
  output logic        o_data,
  output logic        o_write,
  output logic [15:0] o_off
);

  // Counter is loaded with WAIT_STATES-1 so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [1:0]  r_state, w_state_d;
  logic [2:0]  r_cnt, w_cnt_d;
  logic [15:0] r_off, w_off_d;
  logic        r_write, w_write_d;
  logic        w_accept;

  assign o_hready = (r_state != WAIT);
  assign o_data   = (r_state == DATA);
  assign o_write  = r_write;
  assign o_off    = r_off;
  assign w_accept = i_hsel & i_htrans & o_hready;

  // Next-state: advance wait/data phases, and an accepted request overrides the default.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_off_d   = r_off;
    w_write_d = r_write;
    case (r_state)
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_d = DATA;
        end else begin
          w_cnt_d = r_cnt - 3'd1;
        end
      end
      DATA:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    if (w_accept) begin
      w_off_d   = i_haddr - BASE[15:0];
      w_write_d = i_hwrite;
      w_state_d = (WAIT_STATES > 0) ? WAIT : DATA;
      w_cnt_d   = WAIT_LOAD;
    end
  end

  // State registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_off   <= 16'd0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_off   <= w_off_d;
      r_write <= w_write_d;
    end
  end

endmodule

// File: rtl/clint_responder.sv
// CLINT-style timer responder: mtime, mtimecmp and msip behind a simple bus handshake.
module clint_responder
  import clint_responder_pkg::*;
#(
  parameter logic [63:0] BASE        = 64'h0200_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HSEL,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic          w_data;
  logic          w_write;
  logic [15:0]   w_off;
  logic          w_wr;
  logic [47:0]   w_unused_haddr;
  logic [63:0]   w_rdata;
  logic          w_tick;

  logic [63:0]   r_mtime, w_mtime_d;
  logic [63:0]   r_mtimecmp, w_mtimecmp_d;
  logic          r_msip, w_msip_d;
  logic [PW-1:0] r_pre, w_pre_d;
  logic          r_timer_irq, r_soft_irq;
  logic [63:0]   r_hrdata;

  // The window decode is done upstream; only the low 16 address bits matter here.
  assign w_unused_haddr = HADDR[63:16];

  clint_responder_bus_resp_fsm #(
    .BASE        (BASE),
    .WAIT_STATES (WAIT_STATES)
  ) u_fsm (
    .i_clk    (CLK),
    .i_rst_n  (RESET),
    .i_hsel   (HSEL),
    .i_htrans (HTRANS),
    .i_haddr  (HADDR[15:0]),
    .i_hwrite (HWRITE),
    .o_hready (HREADY),
    .o_data   (w_data),
    .o_write  (w_write),
    .o_off    (w_off)
  );

  assign w_wr = w_data & w_write;

  // Read mux: current register values; unmapped offsets read zero.
  always_comb begin
    w_rdata = 64'd0;
    if (off_match(w_off, MSIP_OFF)) begin
      w_rdata = {63'd0, r_msip};
    end else if (off_match(w_off, MTIMECMP_OFF)) begin
      w_rdata = r_mtimecmp;
    end else if (off_match(w_off, MTIME_OFF)) begin
      w_rdata = r_mtime;
    end
  end

  // Read data is live during a read data phase and held otherwise.
  assign HRDATA = (w_data & ~w_write) ? w_rdata : r_hrdata;

  assign w_tick = (r_pre == PW'(PRESCALE - 1));

  // Timer next-state: prescaled increment, bus writes override the increment.
  always_comb begin
    w_pre_d      = w_tick ? '0 : r_pre + PW'(1);
    w_mtime_d    = w_tick ? r_mtime + 64'd1 : r_mtime;
    w_mtimecmp_d = r_mtimecmp;
    w_msip_d     = r_msip;
    if (w_wr && off_match(w_off, MTIME_OFF)) begin
      w_mtime_d = HWDATA;
    end
    if (w_wr && off_match(w_off, MTIMECMP_OFF)) begin
      w_mtimecmp_d = HWDATA;
    end
    if (w_wr && off_match(w_off, MSIP_OFF)) begin
      w_msip_d = HWDATA[0];
    end
  end

  // Register state; interrupt lines follow the next-state values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mtime     <= 64'd0;
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip      <= 1'b0;
      r_pre       <= '0;
      r_timer_irq <= 1'b0;
      r_soft_irq  <= 1'b0;
      r_hrdata    <= 64'd0;
    end else begin
      r_mtime     <= w_mtime_d;
      r_mtimecmp  <= w_mtimecmp_d;
      r_msip      <= w_msip_d;
      r_pre       <= w_pre_d;
      r_timer_irq <= (w_mtime_d >= w_mtimecmp_d);
      r_soft_irq  <= w_msip_d;
      if (w_data && !w_write) begin
        r_hrdata <= w_rdata;
      end
    end
  end

  assign timer_irq = r_timer_irq;
  assign soft_irq  = r_soft_irq;

endmodule

// File: tb/tb_clint_responder.sv
// Scoreboard bench for clint_responder: a zero-wait instance and a two-wait, prescale-3 one.
module tb_clint_responder;
  import clint_responder_pkg::*;

  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam int unsigned PS0 = 1;
  localparam int unsigned PS1 = 3;
  localparam int unsigned WS0 = 0;
  localparam int unsigned WS1 = 2;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel0 = 1'b0, hsel1 = 1'b0, htrans = 1'b0, hwrite = 1'b0;
  logic [63:0] haddr = 64'd0, hwdata = 64'd0;
  logic [63:0] hrdata0, hrdata1;
  logic        hready0, hready1, tirq0, tirq1, sirq0, sirq1;

  always #5 clk = ~clk;

  clint_responder #(.BASE(BASE), .WAIT_STATES(WS0), .PRESCALE(PS0)) u_dut0 (
    .CLK(clk), .RESET(rst_n), .HSEL(hsel0), .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite),
    .HWDATA(hwdata), .HRDATA(hrdata0), .HREADY(hready0), .timer_irq(tirq0), .soft_irq(sirq0)
  );

  clint_responder #(.BASE(BASE), .WAIT_STATES(WS1), .PRESCALE(PS1)) u_dut1 (
    .CLK(clk), .RESET(rst_n), .HSEL(hsel1), .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite),
    .HWDATA(hwdata), .HRDATA(hrdata1), .HREADY(hready1), .timer_irq(tirq1), .soft_irq(sirq1)
  );

  // Edges since the last reset release.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int cur = 0;
  logic        hrdy_c, tirq_c;
  logic [63:0] hrdata_c;
  assign hrdy_c   = (cur == 1) ? hready1 : hready0;
  assign tirq_c   = (cur == 1) ? tirq1 : tirq0;
  assign hrdata_c = (cur == 1) ? hrdata1 : hrdata0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned n;
    logic        rd;
    logic [63:0] exp;
    logic [63:0] wd;
    logic        irq;
    string       tag;
  } ent_t;

  ent_t sb[$];
  event ev_acc;

  // Timer reference: mtime after edge m = x + m/P - w/P, where x was loaded at edge w.
  logic [63:0] mt_x[2];
  int unsigned mt_w[2];
  logic [63:0] mt_cmp[2];

  function automatic int unsigned ps(input int d);
    return (d == 1) ? PS1 : PS0;
  endfunction

  function automatic logic [63:0] mtime_at(input int d, input int unsigned m);
    return mt_x[d] + 64'(m / ps(d)) - 64'(mt_w[d] / ps(d));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mt_x[d]   = 64'd0;
      mt_w[d]   = 0;
      mt_cmp[d] = ONES;
    end
  endtask

  task automatic bus_off();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 1'b0;
    hwrite = 1'b0;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus_off();
  endtask

  // Present one request, hold it until accepted, and push what its data phase must show.
  task automatic bus_access(input logic wr, input logic [15:0] off, input logic [63:0] wd,
                            input logic [63:0] exp, input string tag);
    ent_t e;
    int g = 0;
    int unsigned n;
    @(negedge clk);
    hsel0  = (cur == 0);
    hsel1  = (cur == 1);
    htrans = 1'b1;
    hwrite = wr;
    haddr  = BASE + {48'h0, off};
    while (!hrdy_c && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!hrdy_c) begin
      check({tag, "_accept_timeout"}, {63'h0, hrdy_c}, 64'h1);
      return;
    end
    n     = cyc + 1 + ((cur == 1) ? WS1 : WS0);
    e.n   = n;
    e.rd  = !wr;
    e.wd  = wd;
    e.tag = tag;
    e.exp = exp;
    e.irq = (mtime_at(cur, n) >= mt_cmp[cur]);
    if (off == MTIME_OFF) begin
      if (wr) begin
        mt_x[cur] = wd;
        mt_w[cur] = n + 1;
      end else begin
        e.exp = mtime_at(cur, n);
      end
    end
    if (wr && off == MTIMECMP_OFF) mt_cmp[cur] = wd;
    sb.push_back(e);
    @(posedge clk);
    -> ev_acc;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 50) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    int g = 0;
    while (cyc < n && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc != n) check("wait_cyc", 64'(cyc), 64'(n));
  endtask

  // Data-phase monitor: pops the scoreboard, drives write data, checks read data.
  always begin : monitor
    ent_t e;
    @(posedge clk);
    #1;
    if (rst_n && sb.size() > 0) begin
      if (sb[0].n == cyc) begin
        e = sb.pop_front();
        check({e.tag, "_hready"}, {63'h0, hrdy_c}, 64'h1);
        if (e.rd) begin
          check({e.tag, "_hrdata"}, hrdata_c, e.exp);
          check({e.tag, "_tirq"}, {63'h0, tirq_c}, {63'h0, e.irq});
        end else begin
          hwdata = e.wd;
        end
      end else if (sb[0].n < cyc) begin
        e = sb.pop_front();
        check({e.tag, "_missed"}, 64'(cyc), 64'(e.n));
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int lows = 0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hready0", {63'h0, hready0}, 64'h1);
    check("rst_hready1", {63'h0, hready1}, 64'h1);
    check("rst_hrdata0", hrdata0, 64'h0);
    check("rst_hrdata1", hrdata1, 64'h0);
    check("rst_tirq0", {63'h0, tirq0}, 64'h0);
    check("rst_sirq0", {63'h0, sirq0}, 64'h0);
    check("rst_tirq1", {63'h0, tirq1}, 64'h0);
    check("rst_sirq1", {63'h0, sirq1}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait instance: first mtime read, mtimecmp write, pipelined mtime polling.
    cur = 0;
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "mt_first");
    bus_idle();
    drain();
    bus_access(1'b1, MTIMECMP_OFF, 64'h40, 64'h0, "wr_cmp");
    for (int i = 0; i < 4; i++) bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "mt_poll");
    bus_access(1'b0, MTIMECMP_OFF, 64'h0, 64'h40, "rd_cmp");
    bus_idle();
    drain();
    wait_cyc(63);
    check("tirq_before", {63'h0, tirq0}, 64'h0);
    @(posedge clk);
    #1;
    check("tirq_rise", {63'h0, tirq0}, 64'h1);

    // msip set and clear; soft_irq follows one cycle after the data phase.
    bus_access(1'b1, MSIP_OFF, 64'hF0F1, 64'h0, "wr_msip1");
    #1;
    check("sirq_in_data1", {63'h0, sirq0}, 64'h0);
    bus_off();
    @(posedge clk);
    #1;
    check("sirq_set", {63'h0, sirq0}, 64'h1);
    bus_access(1'b0, MSIP_OFF, 64'h0, 64'h1, "rd_msip1");
    bus_idle();
    drain();
    bus_access(1'b1, MSIP_OFF, 64'h2, 64'h0, "wr_msip0");
    #1;
    check("sirq_in_data0", {63'h0, sirq0}, 64'h1);
    bus_off();
    @(posedge clk);
    #1;
    check("sirq_clr", {63'h0, sirq0}, 64'h0);
    bus_access(1'b0, MSIP_OFF, 64'h0, 64'h0, "rd_msip0");
    bus_idle();
    drain();

    // mtime write beats the coincident increment, then wraps to zero.
    bus_access(1'b1, MTIME_OFF, ONES, 64'h0, "wr_mt_max");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "mt_kept");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "mt_wrap");
    bus_idle();
    drain();

    // Unmapped offset: write dropped, reads zero, neighbours intact.
    bus_access(1'b1, 16'h0008, 64'hDEAD, 64'h0, "wr_unmapped");
    bus_access(1'b0, 16'h0008, 64'h0, 64'h0, "rd_unmapped");
    bus_access(1'b0, MTIMECMP_OFF, 64'h0, 64'h40, "rd_cmp_kept");
    bus_access(1'b0, MSIP_OFF, 64'h0, 64'h0, "rd_msip_kept");
    bus_idle();
    drain();

    // Two-wait, prescale-3 instance.
    cur = 1;
    bus_access(1'b0, MTIMECMP_OFF, 64'h0, ONES, "c1_cmp_rst");
    bus_idle();
    drain();
    bus_access(1'b1, MTIMECMP_OFF, 64'h10, 64'h0, "c1_wr_cmp");
    bus_idle();
    drain();
    fork
      begin
        bus_access(1'b0, MTIMECMP_OFF, 64'h0, 64'h10, "c1_rd_cmp");
        bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "c1_rd_mt_held");
        bus_idle();
      end
      begin
        @(ev_acc);
        for (int i = 0; i < 6; i++) begin
          #1;
          if (!hready1) lows++;
          @(posedge clk);
        end
      end
    join
    check("c1_wait_lows", 64'(lows), 64'd4);
    drain();
    bus_access(1'b1, MTIME_OFF, ONES, 64'h0, "c1_wr_mt");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "c1_mt_a");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "c1_mt_b");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "c1_mt_c");
    bus_idle();
    drain();

    // Reset during a wait cycle aborts the write and frees the bus at once.
    bus_access(1'b1, MTIMECMP_OFF, 64'h77, 64'h0, "c1_wr_abort");
    #1;
    check("c1_in_wait", {63'h0, hready1}, 64'h0);
    rst_n = 1'b0;
    #1;
    check("c1_rst_hready", {63'h0, hready1}, 64'h1);
    bus_off();
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_access(1'b0, MTIMECMP_OFF, 64'h0, ONES, "c1_cmp_after_rst");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "c1_mt_after_rst");
    bus_idle();
    drain();
    cur = 0;
    bus_access(1'b0, MTIMECMP_OFF, 64'h0, ONES, "c0_cmp_after_rst");
    bus_access(1'b0, MTIME_OFF, 64'h0, 64'h0, "c0_mt_after_rst");
    bus_idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
